// File: rtl/pattern_correlator.sv
// Serial pattern correlator: matches a loaded LEN-bit reference against a sliding window of sig, within err_tol mismatches.
// Latency 1 cycle from a sig_valid sample to out/mism_cnt. There is no backpressure: any input bit that is valid in an accepting state is taken.
module pattern_correlator #(
  parameter int LEN   = 1024,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             prgm_start,
  input  logic             prgm_valid,
  input  logic             prgm_bit,
  input  logic             sig_valid,
  input  logic             sig,
  input  logic [CNT_W-1:0] err_tol,
  output logic             out,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;

  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [LEN-1:0]   pat, win, win_nxt;
  logic [CNT_W-1:0] ld_cnt, win_cnt, win_cnt_nxt, pop;
  logic             sample, load_done, win_full;

  assign sample      = sig_valid && (state == FILL || state == RUN);
  assign load_done   = (state == LOAD) && prgm_valid && (ld_cnt == LAST_C);
  assign win_nxt     = {win[LEN-2:0], sig};
  assign win_cnt_nxt = (win_cnt == LEN_C) ? LEN_C : win_cnt + ONE_C;
  assign win_full    = (win_cnt_nxt == LEN_C);

  // pat[LEN-1] (first bit loaded) lines up with win[LEN-1] (oldest sample)
  always_comb begin
    pop = '0;
    for (int i = 0; i < LEN; i++) begin
      pop = pop + CNT_W'(win_nxt[i] ^ pat[i]);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (prgm_start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (load_done) state_nxt = FILL;
        FILL:    if (sig_valid && win_full) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pat      <= '0;
      win      <= '0;
      ld_cnt   <= '0;
      win_cnt  <= '0;
      out      <= 1'b0;
      mism_cnt <= '0;
      loaded   <= 1'b0;
    end else if (prgm_start) begin
      // a bit arriving with the start pulse is the first bit of the new pattern
      pat      <= prgm_valid ? {{(LEN-1){1'b0}}, prgm_bit} : '0;
      ld_cnt   <= prgm_valid ? ONE_C : '0;
      win      <= '0;
      win_cnt  <= '0;
      out      <= 1'b0;
      mism_cnt <= '0;
      loaded   <= 1'b0;
    end else begin
      if (state == LOAD && prgm_valid) begin
        pat    <= {pat[LEN-2:0], prgm_bit};
        ld_cnt <= ld_cnt + ONE_C;
        if (load_done) begin
          loaded  <= 1'b1;
          win     <= '0;
          win_cnt <= '0;
        end
      end
      if (sample) begin
        win      <= win_nxt;
        win_cnt  <= win_cnt_nxt;
        mism_cnt <= pop;
        out      <= win_full && (pop <= err_tol);
      end
    end
  end

endmodule
